store_pack: RTL

Store-side narrowing and packing unit between the MEM stage and the data memory write port. It accepts a 32-bit register value, a byte address and a store width (sw/sh/sb). It replicates the data into the correct byte lanes, generates byte enables, and word-aligns the address. Packed writes are held in a small FIFO and drained to memory over a valid/ready handshake. Misaligned or illegal stores are consumed without a write and flagged.

---
 rtl/store_pack.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/store_pack.sv
// ---------------------------------------------------------------------------
// store_pack
//
// Store-side narrowing and packing unit sitting between the MEM stage and the
// data-memory write port. An incoming store (32-bit register value, byte
// address, width sw/sh/sb) is lane-replicated, given byte enables and a
// word-aligned address, then buffered in a small FIFO. The FIFO head is
// drained to memory over a valid/ready handshake. Misaligned or illegal
// stores are consumed without producing a write and are flagged on st_err
// one cycle later.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   st_valid   in   store request valid
//   st_ready   out  request can be accepted (FIFO not full)
//   st_op      in   2'b00 sw, 2'b01 sh, 2'b10 sb, 2'b11 illegal
//   st_addr    in   byte address
//   st_data    in   source register value
//   st_err     out  one-cycle pulse: previous accepted request was dropped
//   mem_valid  out  FIFO head valid
//   mem_ready  in   memory accepts the head entry
//   mem_addr   out  word-aligned address of head entry
//   mem_wdata  out  lane-replicated write data of head entry
//   mem_be     out  byte enables of head entry (bit i = bits [8i+7:8i])
//   count      out  number of occupied entries
// ---------------------------------------------------------------------------
module store_pack #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [1:0]                 st_op,
    input  logic [31:0]                st_addr,
    input  logic [31:0]                st_data,
    output logic                       st_err,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [3:0]                 mem_be,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [1:0] OP_SW = 2'b00;
    localparam logic [1:0] OP_SH = 2'b01;
    localparam logic [1:0] OP_SB = 2'b10;

    // ------------------------------------------------------------------
    // Packing of the incoming request
    // ------------------------------------------------------------------
    logic [31:0] pack_wdata;
    logic [3:0]  pack_be;
    logic        pack_legal;
    logic [3:0]  sb_be;

    // One-hot byte lane select for byte stores.
    for (genvar gi = 0; gi < 4; gi++) begin : g_sb_lane
        assign sb_be[gi] = (st_addr[1:0] == 2'(gi));
    end

    always_comb begin
        pack_wdata = st_data;
        pack_be    = 4'b0000;
        pack_legal = 1'b0;
        case (st_op)
            OP_SW: begin
                pack_wdata = st_data;
                pack_be    = 4'b1111;
                pack_legal = (st_addr[1:0] == 2'b00);
            end
            OP_SH: begin
                pack_wdata = {2{st_data[15:0]}};
                pack_be    = st_addr[1] ? 4'b1100 : 4'b0011;
                pack_legal = ~st_addr[0];
            end
            OP_SB: begin
                pack_wdata = {4{st_data[7:0]}};
                pack_be    = sb_be;
                pack_legal = 1'b1;
            end
            default: begin
                pack_wdata = st_data;
                pack_be    = 4'b0000;
                pack_legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [CW-1:0] count_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic          st_err_reg;

    logic accept;
    logic push;
    logic pop;

    // st_ready depends on the registered count only, so mem_ready never
    // reaches st_ready combinationally; a full FIFO stalls even on a pop.
    assign st_ready = (count_reg != FULL_COUNT);
    assign accept   = st_valid && st_ready;
    assign push     = accept && pack_legal;
    assign pop      = mem_valid && mem_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            st_err_reg <= 1'b0;
        end else begin
            st_err_reg <= accept && !pack_legal;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry storage. Cleared on reset so the head outputs read zero.
    // ------------------------------------------------------------------
    logic [31:0] addr_mem  [DEPTH];
    logic [31:0] wdata_mem [DEPTH];
    logic [3:0]  be_mem    [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i]  <= '0;
                wdata_mem[i] <= '0;
                be_mem[i]    <= '0;
            end
        end else if (push) begin
            addr_mem[wr_ptr_reg]  <= {st_addr[31:2], 2'b00};
            wdata_mem[wr_ptr_reg] <= pack_wdata;
            be_mem[wr_ptr_reg]    <= pack_be;
        end
    end

    // Head fields come straight from storage registers; when the FIFO is
    // empty they show whatever the slot last held.
    assign mem_valid = (count_reg != '0);
    assign mem_addr  = addr_mem[rd_ptr_reg];
    assign mem_wdata = wdata_mem[rd_ptr_reg];
    assign mem_be    = be_mem[rd_ptr_reg];
    assign count     = count_reg;
    assign st_err    = st_err_reg;

endmodule
